// File: rtl/ins_fetch_seq.sv
// Instruction fetch sequencer: holds the PC, fetches words over a req/ack handshake and advances the PC on exec_done.
// Optional INS_TIMEOUT_EN bounds the WAIT state and raises a sticky fetch_err on expiry.
module ins_fetch_seq #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned INS_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             J,
  input  logic             exec_done,
  output logic             ins_req,
  output logic [PC_W-1:0]  ins_addr,
  input  logic             ins_ack,
  input  logic [INS_W-1:0] ins_rdata,
  output logic [INS_W-1:0] ins_out,
  output logic             ins_valid,
  output logic [PC_W-1:0]  pc_out,
  output logic             busy,
  output logic             fetch_err
);

  // Handshake: ins_req is held with a stable ins_addr until the cycle ins_ack is
  // high; that cycle transfers ins_rdata. ins_ack in any other cycle is ignored.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] ir_q, ir_d;

`ifdef INS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
`ifdef INS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef INS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef INS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && !halt_req) state_d = ST_REQ;
      end
      ST_REQ: begin
`ifdef INS_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (ins_ack) begin
          ir_d    = ins_rdata;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ins_ack) begin
          ir_d    = ins_rdata;
          state_d = ST_HOLD;
        end
`ifdef INS_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          // Give up; PC is left alone so the next start retries the same address.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_HOLD: begin
        if (exec_done) begin
          pc_d    = J ? ir_q[PC_W-1:0] : pc_q + 1'b1;
          state_d = halt_req ? ST_IDLE : ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ins_req   = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign ins_addr  = pc_q;
  assign ins_out   = ir_q;
  assign ins_valid = (state_q == ST_HOLD);
  assign pc_out    = pc_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef INS_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ins_fetch_seq.sv
// Bench for ins_fetch_seq: directed cases from the plan, then random instruction streams
// checked against a PC/IR model kept as plain variables and a memory array.
module tb_ins_fetch_seq;

  localparam int PC_W  = 8;
  localparam int INS_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             halt_req = 1'b0;
  logic             J = 1'b0;
  logic             exec_done = 1'b0;
  logic             ins_req;
  logic [PC_W-1:0]  ins_addr;
  logic             ins_ack = 1'b0;
  logic [INS_W-1:0] ins_rdata = '0;
  logic [INS_W-1:0] ins_out;
  logic             ins_valid;
  logic [PC_W-1:0]  pc_out;
  logic             busy;
  logic             fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PC_W-1:0]  model_pc;
  logic [INS_W-1:0] mem [256];
  logic [31:0]      exp_q[$];

  ins_fetch_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .J(J),
    .exec_done(exec_done), .ins_req(ins_req), .ins_addr(ins_addr),
    .ins_ack(ins_ack), .ins_rdata(ins_rdata), .ins_out(ins_out),
    .ins_valid(ins_valid), .pc_out(pc_out), .busy(busy), .fetch_err(fetch_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_req", {31'd0, ins_req}, 32'd1);
    check("start_addr", {24'd0, ins_addr}, {24'd0, model_pc});
  endtask

  // One full instruction: fetch with `delay` stall cycles, hold, then exec_done.
  // Returns with the sequencer either in REQ (next fetch) or IDLE (halted).
  task automatic do_insn(input logic [INS_W-1:0] data, input int delay,
                         input logic j, input logic halt);
    logic [PC_W-1:0] addr0;
    addr0 = model_pc;
    check("req_at_entry", {31'd0, ins_req}, 32'd1);
    check("addr_at_entry", {24'd0, ins_addr}, {24'd0, addr0});
    for (int i = 0; i < delay; i++) begin
      ins_ack = 1'b0;
      if (halt) halt_req = 1'b1;
      tick();
      check("wait_req", {31'd0, ins_req}, 32'd1);
      check("wait_addr", {24'd0, ins_addr}, {24'd0, addr0});
      check("wait_no_valid", {31'd0, ins_valid}, 32'd0);
    end
    if (halt) halt_req = 1'b1;
    ins_ack   = 1'b1;
    ins_rdata = data;
    tick();
    ins_ack   = 1'b0;
    ins_rdata = INS_W'($urandom);
    exp_q.push_back({16'd0, data});
    check("hold_valid", {31'd0, ins_valid}, 32'd1);
    check("hold_ir", {16'd0, ins_out}, exp_q.pop_front());
    check("hold_no_req", {31'd0, ins_req}, 32'd0);
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      J       = 1'($urandom);
      ins_ack = 1'($urandom);
      tick();
      ins_ack = 1'b0;
      check("hold_stays", {31'd0, ins_valid}, 32'd1);
      check("hold_ir_kept", {16'd0, ins_out}, {16'd0, data});
    end
    J         = j;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    J         = 1'($urandom);
    model_pc  = j ? data[PC_W-1:0] : PC_W'(model_pc + 1);
    check("post_valid", {31'd0, ins_valid}, 32'd0);
    check("post_pc", {24'd0, pc_out}, {24'd0, model_pc});
    if (halt) begin
      check("halt_busy", {31'd0, busy}, 32'd0);
      check("halt_req_low", {31'd0, ins_req}, 32'd0);
      check("idle_ir_kept", {16'd0, ins_out}, {16'd0, data});
      halt_req = 1'b0;
    end else begin
      check("next_req", {31'd0, ins_req}, 32'd1);
      check("next_addr", {24'd0, ins_addr}, {24'd0, model_pc});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = INS_W'($urandom);
    model_pc = '0;
    #2;
    check("rst_req", {31'd0, ins_req}, 32'd0);
    check("rst_pc", {24'd0, pc_out}, 32'd0);
    check("rst_ir", {16'd0, ins_out}, 32'd0);
    check("rst_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Directed: one-cycle fetch, jumps, wrap, stall, self-loop.
    do_start();
    do_insn(16'h1234, 0, 1'b0, 1'b0);
    do_insn(16'h0005, 1, 1'b1, 1'b0);
    check("at_pc5", {24'd0, pc_out}, 32'h05);
    do_insn(16'h0A3C, 0, 1'b1, 1'b0);
    check("jump_3c", {24'd0, ins_addr}, 32'h3C);
    do_insn(16'h0005, 2, 1'b1, 1'b0);
    do_insn(16'h0A3C, 0, 1'b0, 1'b0);
    check("seq_06", {24'd0, ins_addr}, 32'h06);
    do_insn(16'h77FF, 0, 1'b1, 1'b0);
    do_insn(16'h5555, 3, 1'b0, 1'b0);
    check("wrap_00", {24'd0, ins_addr}, 32'h00);
    do_insn(16'hAB00, 1, 1'b1, 1'b0);
    check("self_loop", {24'd0, ins_addr}, 32'h00);

    // Halt raised during WAIT, then start+halt together stays idle.
    do_insn(16'h4242, 2, 1'b0, 1'b1);
    halt_req = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    halt_req = 1'b0;
    check("start_halt_idle", {31'd0, busy}, 32'd0);
    check("start_halt_noreq", {31'd0, ins_req}, 32'd0);
    do_start();

    // Reset in the middle of WAIT.
    tick();
    tick();
    check("pre_rst_wait", {31'd0, ins_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, ins_req}, 32'd0);
    check("midrst_pc", {24'd0, pc_out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    model_pc = '0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef INS_TIMEOUT_EN
    do_start();
    do_insn(16'h0010, 0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    check("to_still_wait", {31'd0, ins_req}, 32'd1);
    check("to_no_err_yet", {31'd0, fetch_err}, 32'd0);
    tick();
    check("to_req_drop", {31'd0, ins_req}, 32'd0);
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_idle", {31'd0, busy}, 32'd0);
    check("to_pc_kept", {24'd0, pc_out}, 32'h10);
    do_start();
    do_insn(16'h0001, 0, 1'b0, 1'b1);
    check("to_err_sticky", {31'd0, fetch_err}, 32'd1);
    rst_n = 1'b0;
    model_pc = '0;
    tick();
    rst_n = 1'b1;
    tick();
`endif

    // Random instruction stream over the memory array.
    do_start();
    for (int n = 0; n < 200; n++) begin
      logic h;
      h = ($urandom_range(0, 9) == 0);
      do_insn(mem[model_pc], int'($urandom_range(0, 4)), 1'($urandom), h);
      if (h) begin
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
          tick();
          check("halt_idle_stays", {31'd0, busy}, 32'd0);
        end
        do_start();
      end
    end
    check("no_err_default", {31'd0, fetch_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
